// File: rtl/alu_reservation_station.sv
// Reservation station in front of the scalar ALU: buffers dispatched ops, wakes
// operands from the ALU and load/store broadcast buses, issues one ready entry per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE_BIT = 3,
  parameter int TYPE_BIT    = 6,
  parameter int ROB_BIT     = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic                inst_valid,
  input  logic [TYPE_BIT-1:0] inst_type,
  input  logic                inst_r1_has_dep,
  input  logic [ROB_BIT-1:0]  inst_r1_dep,
  input  logic [31:0]         inst_r1_val,
  input  logic                inst_r2_has_dep,
  input  logic [ROB_BIT-1:0]  inst_r2_dep,
  input  logic [31:0]         inst_r2_val,
  input  logic [ROB_BIT-1:0]  inst_rob_id,
  output logic                full,
  input  logic                alu_res_ready,
  input  logic [ROB_BIT-1:0]  alu_res_rob_id,
  input  logic [31:0]         alu_res_value,
  input  logic                lsb_res_ready,
  input  logic [ROB_BIT-1:0]  lsb_res_rob_id,
  input  logic [31:0]         lsb_res_value,
  output logic                alu_valid,
  output logic [TYPE_BIT-1:0] alu_type,
  output logic [31:0]         alu_r1,
  output logic [31:0]         alu_r2,
  output logic [ROB_BIT-1:0]  alu_rob_id
);

  localparam int unsigned RS_SIZE = 1 << RS_SIZE_BIT;

  logic [RS_SIZE-1:0]  busy_q, busy_d;
  logic [TYPE_BIT-1:0] type_q [RS_SIZE];
  logic [TYPE_BIT-1:0] type_d [RS_SIZE];
  logic [ROB_BIT-1:0]  rob_q  [RS_SIZE];
  logic [ROB_BIT-1:0]  rob_d  [RS_SIZE];
  logic [RS_SIZE-1:0]  h1_q, h1_d, h2_q, h2_d;
  logic [ROB_BIT-1:0]  dep1_q [RS_SIZE];
  logic [ROB_BIT-1:0]  dep1_d [RS_SIZE];
  logic [ROB_BIT-1:0]  dep2_q [RS_SIZE];
  logic [ROB_BIT-1:0]  dep2_d [RS_SIZE];
  logic [31:0]         val1_q [RS_SIZE];
  logic [31:0]         val1_d [RS_SIZE];
  logic [31:0]         val2_q [RS_SIZE];
  logic [31:0]         val2_d [RS_SIZE];

  logic                alu_valid_q, alu_valid_d;
  logic [TYPE_BIT-1:0] alu_type_q, alu_type_d;
  logic [31:0]         alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d;
  logic [ROB_BIT-1:0]  alu_rob_id_q, alu_rob_id_d;

  logic [RS_SIZE_BIT-1:0] sel, free;
  logic                   sel_found, free_found;

  function automatic logic hit(input logic rdy, input logic [ROB_BIT-1:0] bus,
                               input logic [ROB_BIT-1:0] dep);
    return rdy && (bus == dep);
  endfunction

  assign full       = &busy_q;
  assign alu_valid  = alu_valid_q;
  assign alu_type   = alu_type_q;
  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
  assign alu_rob_id = alu_rob_id_q;

  always_comb begin
    busy_d = busy_q;  type_d = type_q;  rob_d = rob_q;
    h1_d = h1_q;  dep1_d = dep1_q;  val1_d = val1_q;
    h2_d = h2_q;  dep2_d = dep2_q;  val2_d = val2_q;
    alu_valid_d  = alu_valid_q;
    alu_type_d   = alu_type_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    alu_rob_id_d = alu_rob_id_q;
    sel = '0;  sel_found = 1'b0;
    free = '0; free_found = 1'b0;

    // Select and free-slot search both look only at registered state.
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!sel_found && busy_q[i] && !h1_q[i] && !h2_q[i]) begin
        sel = RS_SIZE_BIT'(i);
        sel_found = 1'b1;
      end
      if (!free_found && !busy_q[i]) begin
        free = RS_SIZE_BIT'(i);
        free_found = 1'b1;
      end
    end

    if (rdy_in) begin
      if (flush) begin
        busy_d      = '0;
        alu_valid_d = 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            if (h1_q[i] && hit(alu_res_ready, alu_res_rob_id, dep1_q[i])) begin
              h1_d[i] = 1'b0; val1_d[i] = alu_res_value;
            end else if (h1_q[i] && hit(lsb_res_ready, lsb_res_rob_id, dep1_q[i])) begin
              h1_d[i] = 1'b0; val1_d[i] = lsb_res_value;
            end
            if (h2_q[i] && hit(alu_res_ready, alu_res_rob_id, dep2_q[i])) begin
              h2_d[i] = 1'b0; val2_d[i] = alu_res_value;
            end else if (h2_q[i] && hit(lsb_res_ready, lsb_res_rob_id, dep2_q[i])) begin
              h2_d[i] = 1'b0; val2_d[i] = lsb_res_value;
            end
          end
        end

        alu_valid_d = sel_found;
        if (sel_found) begin
          alu_type_d   = type_q[sel];
          alu_r1_d     = val1_q[sel];
          alu_r2_d     = val2_q[sel];
          alu_rob_id_d = rob_q[sel];
          busy_d[sel]  = 1'b0;
        end

        if (inst_valid && free_found) begin
          busy_d[free] = 1'b1;
          type_d[free] = inst_type;
          rob_d[free]  = inst_rob_id;
          h1_d[free] = inst_r1_has_dep; dep1_d[free] = inst_r1_dep; val1_d[free] = inst_r1_val;
          h2_d[free] = inst_r2_has_dep; dep2_d[free] = inst_r2_dep; val2_d[free] = inst_r2_val;
          if (inst_r1_has_dep && hit(alu_res_ready, alu_res_rob_id, inst_r1_dep)) begin
            h1_d[free] = 1'b0; val1_d[free] = alu_res_value;
          end else if (inst_r1_has_dep && hit(lsb_res_ready, lsb_res_rob_id, inst_r1_dep)) begin
            h1_d[free] = 1'b0; val1_d[free] = lsb_res_value;
          end
          if (inst_r2_has_dep && hit(alu_res_ready, alu_res_rob_id, inst_r2_dep)) begin
            h2_d[free] = 1'b0; val2_d[free] = alu_res_value;
          end else if (inst_r2_has_dep && hit(lsb_res_ready, lsb_res_rob_id, inst_r2_dep)) begin
            h2_d[free] = 1'b0; val2_d[free] = lsb_res_value;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      h1_q   <= '0;
      h2_q   <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        type_q[i] <= '0;  rob_q[i]  <= '0;
        dep1_q[i] <= '0;  val1_q[i] <= '0;
        dep2_q[i] <= '0;  val2_q[i] <= '0;
      end
      alu_valid_q  <= 1'b0;
      alu_type_q   <= '0;
      alu_r1_q     <= '0;
      alu_r2_q     <= '0;
      alu_rob_id_q <= '0;
    end else begin
      busy_q <= busy_d;  type_q <= type_d;  rob_q <= rob_d;
      h1_q <= h1_d;  dep1_q <= dep1_d;  val1_q <= val1_d;
      h2_q <= h2_d;  dep2_q <= dep2_d;  val2_q <= val2_d;
      alu_valid_q  <= alu_valid_d;
      alu_type_q   <= alu_type_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      alu_rob_id_q <= alu_rob_id_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus random traffic
// compared cycle by cycle against a slot-array reference model.
module tb_alu_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, inst_valid;
  logic [5:0]  inst_type;
  logic        inst_r1_has_dep, inst_r2_has_dep;
  logic [3:0]  inst_r1_dep, inst_r2_dep, inst_rob_id;
  logic [31:0] inst_r1_val, inst_r2_val;
  logic        full;
  logic        alu_res_ready, lsb_res_ready;
  logic [3:0]  alu_res_rob_id, lsb_res_rob_id;
  logic [31:0] alu_res_value, lsb_res_value;
  logic        alu_valid;
  logic [5:0]  alu_type;
  logic [31:0] alu_r1, alu_r2;
  logic [3:0]  alu_rob_id;

  int checks = 0;
  int failures = 0;

  alu_reservation_station #(.RS_SIZE_BIT(3), .TYPE_BIT(6), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .inst_valid(inst_valid), .inst_type(inst_type),
    .inst_r1_has_dep(inst_r1_has_dep), .inst_r1_dep(inst_r1_dep), .inst_r1_val(inst_r1_val),
    .inst_r2_has_dep(inst_r2_has_dep), .inst_r2_dep(inst_r2_dep), .inst_r2_val(inst_r2_val),
    .inst_rob_id(inst_rob_id), .full(full),
    .alu_res_ready(alu_res_ready), .alu_res_rob_id(alu_res_rob_id), .alu_res_value(alu_res_value),
    .lsb_res_ready(lsb_res_ready), .lsb_res_rob_id(lsb_res_rob_id), .lsb_res_value(lsb_res_value),
    .alu_valid(alu_valid), .alu_type(alu_type), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: eight slots, stepped once per clock edge from the bench flow.
  typedef struct {
    logic busy; logic [5:0] typ; logic [3:0] rob;
    logic h1; logic [3:0] d1; logic [31:0] v1;
    logic h2; logic [3:0] d2; logic [31:0] v2;
  } ent_t;
  ent_t        m [8];
  logic        m_valid;
  logic [5:0]  m_type;
  logic [31:0] m_r1, m_r2;
  logic [3:0]  m_rob;

  task automatic resolve(input logic h, input logic [3:0] d, input logic [31:0] v,
                         output logic nh, output logic [31:0] nv);
    nh = h; nv = v;
    if (h && alu_res_ready && d == alu_res_rob_id) begin nh = 0; nv = alu_res_value; end
    else if (h && lsb_res_ready && d == lsb_res_rob_id) begin nh = 0; nv = lsb_res_value; end
  endtask

  function automatic logic m_full();
    for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int pick, slot;
    if (rst_in) begin
      for (int i = 0; i < 8; i++) m[i].busy = 0;
      m_valid = 0; m_type = 0; m_r1 = 0; m_r2 = 0; m_rob = 0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < 8; i++) m[i].busy = 0;
        m_valid = 0;
      end else begin
        pick = -1; slot = -1;
        for (int i = 0; i < 8; i++) begin
          if (pick < 0 && m[i].busy && !m[i].h1 && !m[i].h2) pick = i;
          if (slot < 0 && !m[i].busy) slot = i;
        end
        for (int i = 0; i < 8; i++) if (m[i].busy) begin
          resolve(m[i].h1, m[i].d1, m[i].v1, m[i].h1, m[i].v1);
          resolve(m[i].h2, m[i].d2, m[i].v2, m[i].h2, m[i].v2);
        end
        m_valid = (pick >= 0);
        if (pick >= 0) begin
          m_type = m[pick].typ; m_r1 = m[pick].v1; m_r2 = m[pick].v2; m_rob = m[pick].rob;
          m[pick].busy = 0;
        end
        if (inst_valid && slot >= 0) begin
          m[slot].busy = 1; m[slot].typ = inst_type; m[slot].rob = inst_rob_id;
          m[slot].d1 = inst_r1_dep; m[slot].d2 = inst_r2_dep;
          resolve(inst_r1_has_dep, inst_r1_dep, inst_r1_val, m[slot].h1, m[slot].v1);
          resolve(inst_r2_has_dep, inst_r2_dep, inst_r2_val, m[slot].h2, m[slot].v2);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rdy_in = 1; flush = 0; inst_valid = 0; inst_type = 0;
    inst_r1_has_dep = 0; inst_r1_dep = 0; inst_r1_val = 0;
    inst_r2_has_dep = 0; inst_r2_dep = 0; inst_r2_val = 0; inst_rob_id = 0;
    alu_res_ready = 0; alu_res_rob_id = 0; alu_res_value = 0;
    lsb_res_ready = 0; lsb_res_rob_id = 0; lsb_res_value = 0;
  endtask

  task automatic drive(input logic [5:0] t, input logic h1, input logic [3:0] d1,
                       input logic [31:0] v1, input logic h2, input logic [3:0] d2,
                       input logic [31:0] v2, input logic [3:0] rob);
    inst_valid = 1; inst_type = t;
    inst_r1_has_dep = h1; inst_r1_dep = d1; inst_r1_val = v1;
    inst_r2_has_dep = h2; inst_r2_dep = d2; inst_r2_val = v2; inst_rob_id = rob;
  endtask

  task automatic test_reset();
    rst_in = 1; idle();
    tick(); tick();
    rst_in = 0;
    tick();
    checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", alu_valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if ({alu_type, alu_r1, alu_r2, alu_rob_id} !== '0) begin failures++;
      $display("FAIL reset_outputs got type=%h r1=%h r2=%h rob=%h exp=0", alu_type, alu_r1, alu_r2, alu_rob_id); end
  endtask

  task automatic test_basic();
    drive(6'd0, 0, 0, 32'd5, 0, 0, 32'd7, 4'd3);
    tick(); idle();
    checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL basic_early got=%b exp=0", alu_valid); end
    tick();
    checks++; if ({alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 6'd0, 32'd5, 32'd7, 4'd3}) begin failures++;
      $display("FAIL basic_issue got v=%b t=%h r1=%h r2=%h rob=%h exp v=1 t=0 r1=5 r2=7 rob=3", alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL basic_after got=%b exp=0", alu_valid); end
  endtask

  task automatic test_wakeup();
    drive(6'h08, 1, 4'd2, 32'd0, 0, 0, 32'd1, 4'd4);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL wakeup_wait%0d got=%b exp=0", k, alu_valid); end
    end
    alu_res_ready = 1; alu_res_rob_id = 4'd2; alu_res_value = 32'h10;
    tick(); idle();
    checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL wakeup_latency got=%b exp=0", alu_valid); end
    tick();
    checks++; if ({alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 6'h08, 32'h10, 32'd1, 4'd4}) begin failures++;
      $display("FAIL wakeup_issue got v=%b t=%h r1=%h r2=%h rob=%h exp v=1 t=08 r1=10 r2=1 rob=4", alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id); end
  endtask

  task automatic test_bypass();
    drive(6'h20, 1, 4'd5, 32'hdead, 0, 0, 32'd3, 4'd6);
    lsb_res_ready = 1; lsb_res_rob_id = 4'd5; lsb_res_value = 32'd9;
    tick(); idle();
    tick();
    checks++; if ({alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 6'h20, 32'd9, 32'd3, 4'd6}) begin failures++;
      $display("FAIL bypass_issue got v=%b t=%h r1=%h r2=%h rob=%h exp v=1 t=20 r1=9 r2=3 rob=6", alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id); end
    tick();
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++) begin
      drive(6'(k), 1, 4'd15, 32'd0, 0, 0, 32'(k), 4'(k));
      tick();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", full); end
    drive(6'd1, 0, 0, 32'd99, 0, 0, 32'd99, 4'd9);
    tick(); idle();
    checks++; if ({full, alu_valid} !== 2'b10) begin failures++; $display("FAIL full_ignore got full=%b v=%b exp full=1 v=0", full, alu_valid); end
    alu_res_ready = 1; alu_res_rob_id = 4'd15; alu_res_value = 32'hab;
    tick(); idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if ({alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 6'(k), 32'hab, 32'(k), 4'(k)}) begin failures++;
        $display("FAIL full_order%0d got v=%b t=%h r1=%h r2=%h rob=%h exp v=1 rob=%0d", k, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id, k); end
      if (k == 0) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_drop got=%b exp=0", full); end
      end
    end
    tick();
    checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", alu_valid); end
  endtask

  task automatic test_stall();
    drive(6'd2, 0, 0, 32'd11, 0, 0, 32'd12, 4'd1);
    tick();
    drive(6'd3, 0, 0, 32'd21, 0, 0, 32'd22, 4'd2);
    tick(); idle();
    rdy_in = 0;
    drive(6'd4, 0, 0, 32'd31, 0, 0, 32'd32, 4'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if ({alu_valid, alu_r1, alu_rob_id} !== {1'b1, 32'd11, 4'd1}) begin failures++;
        $display("FAIL stall_hold%0d got v=%b r1=%h rob=%h exp v=1 r1=b rob=1", k, alu_valid, alu_r1, alu_rob_id); end
    end
    idle();
    tick();
    checks++; if ({alu_valid, alu_r1, alu_r2, alu_rob_id} !== {1'b1, 32'd21, 32'd22, 4'd2}) begin failures++;
      $display("FAIL stall_resume got v=%b r1=%h r2=%h rob=%h exp v=1 r1=15 r2=16 rob=2", alu_valid, alu_r1, alu_r2, alu_rob_id); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL stall_lost_dispatch got=%b exp=0", alu_valid); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      drive(6'd5, 1, 4'd14, 32'd0, 0, 0, 32'd0, 4'(8 + k));
      tick();
    end
    drive(6'd6, 0, 0, 32'd1, 0, 0, 32'd2, 4'd13);
    tick(); idle();
    flush = 1;
    tick(); idle();
    checks++; if ({full, alu_valid} !== 2'b00) begin failures++; $display("FAIL flush_clear got full=%b v=%b exp 0 0", full, alu_valid); end
    alu_res_ready = 1; alu_res_rob_id = 4'd14; alu_res_value = 32'h77;
    for (int k = 0; k < 4; k++) begin
      tick(); idle();
      checks++; if (alu_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost%0d got v=%b rob=%h exp v=0", k, alu_valid, alu_rob_id); end
    end
    drive(6'd7, 0, 0, 32'h55, 0, 0, 32'h66, 4'd5);
    tick(); idle();
    tick();
    checks++; if ({alu_valid, alu_rob_id} !== {1'b1, 4'd5}) begin failures++; $display("FAIL async_pre got v=%b rob=%h exp v=1 rob=5", alu_valid, alu_rob_id); end
    #2 rst_in = 1;
    #1;
    checks++; if ({alu_valid, alu_r1, alu_rob_id} !== '0) begin failures++;
      $display("FAIL async_reset got v=%b r1=%h rob=%h exp 0", alu_valid, alu_r1, alu_rob_id); end
    tick();
    rst_in = 0;
  endtask

  task automatic test_random();
    rst_in = 1; idle();
    tick(); model_step();
    rst_in = 0;
    for (int c = 0; c < 600; c++) begin
      rdy_in = ($urandom_range(7) != 0);
      flush = ($urandom_range(39) == 0);
      inst_valid = $urandom_range(1);
      inst_type = 6'($urandom);
      inst_r1_has_dep = $urandom_range(1); inst_r1_dep = 4'($urandom_range(7)); inst_r1_val = $urandom;
      inst_r2_has_dep = $urandom_range(1); inst_r2_dep = 4'($urandom_range(7)); inst_r2_val = $urandom;
      inst_rob_id = 4'($urandom);
      alu_res_ready = ($urandom_range(2) == 0); alu_res_rob_id = 4'($urandom_range(7)); alu_res_value = $urandom;
      lsb_res_ready = ($urandom_range(2) == 0); lsb_res_rob_id = 4'($urandom_range(7)); lsb_res_value = $urandom;
      tick(); model_step();
      checks++; if ({full, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id} !== {m_full(), m_valid, m_type, m_r1, m_r2, m_rob}) begin
        failures++;
        $display("FAIL random_c%0d got full=%b v=%b t=%h r1=%h r2=%h rob=%h exp full=%b v=%b t=%h r1=%h r2=%h rob=%h",
                 c, full, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id, m_full(), m_valid, m_type, m_r1, m_r2, m_rob);
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_stall();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station feeding the scalar ALU. Sits between the dispatch stage and the ALU.
- Buffers up to RS_SIZE decoded ALU/branch ops and tracks operand dependencies by ROB id.
- Captures operand values from two broadcast buses: the ALU result bus and the load/store result bus.
- Each cycle, issues at most one fully-ready entry to the ALU, with the ALU's valid/work_type/r1/r2/rob_id handshake registered.

Parameters:
- RS_SIZE_BIT, 3, log2 of the entry count (RS_SIZE = 8).
- TYPE_BIT, 6, width of work_type. Bit 5 = M-ext, bit 4 = branch compare, bit 3 = sub/sra, bits 2:0 = funct3.
- ROB_BIT, 4, width of a ROB id.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds
- flush  input  1  misprediction clear, synchronous
- inst_valid  input  1  dispatch request
- inst_type  input  TYPE_BIT  op type, passed unchanged to the ALU
- inst_r1_has_dep  input  1  r1 still waiting on a producer
- inst_r1_dep  input  ROB_BIT  producer ROB id for r1
- inst_r1_val  input  32  r1 value; valid when has_dep=0
- inst_r2_has_dep  input  1  r2 still waiting on a producer
- inst_r2_dep  input  ROB_BIT  producer ROB id for r2
- inst_r2_val  input  32  r2 value; valid when has_dep=0
- inst_rob_id  input  ROB_BIT  destination ROB id
- full  output  1  no free entry
- alu_res_ready  input  1  ALU broadcast valid
- alu_res_rob_id  input  ROB_BIT  ALU broadcast ROB id
- alu_res_value  input  32  ALU broadcast value
- lsb_res_ready  input  1  load/store broadcast valid
- lsb_res_rob_id  input  ROB_BIT  load/store broadcast ROB id
- lsb_res_value  input  32  load/store broadcast value
- alu_valid  output  1  issue strobe to the ALU
- alu_type  output  TYPE_BIT  issued op type
- alu_r1  output  32  issued r1 operand
- alu_r2  output  32  issued r2 operand
- alu_rob_id  output  ROB_BIT  issued ROB id

Behaviour:
- Entry state: busy, type, rob_id, and per operand {has_dep, dep, val}.
- Reset (async, rst_in=1): all busy=0; alu_valid=0; alu_type, alu_r1, alu_r2, alu_rob_id = 0.
- full: combinational from registered state; 1 iff all RS_SIZE entries are busy.
- Priority on each rising edge with rst_in=0: rdy_in=0, then flush, then normal operation.
  - rdy_in=0: no state changes, outputs hold; broadcasts that cycle are lost.
  - flush=1: all busy=0, alu_valid=0. Dispatch, wakeup and issue are suppressed that cycle.
- Dispatch:
  - When inst_valid=1 and full=0, the lowest-index free entry is written. The entry becomes busy next cycle.
  - inst_valid=1 while full=1 is ignored; upstream must respect full.
  - An entry freed by issue in the same cycle does not lower full until the next cycle.
- Dispatch bypass:
  - If an operand has_dep=1 and its dep matches a valid broadcast in the same cycle, the entry stores has_dep=0 with the broadcast value.
  - If both buses match, ALU bus wins.
- Wakeup: every busy entry with has_dep=1 whose dep equals a valid broadcast rob_id sets has_dep=0 and val=value. Both operands are checked against both buses independently.
- Select: among entries busy with both has_dep=0 (registered state, before this cycle's wakeup), pick the lowest index.
  - An operand woken in cycle t is issuable at edge t+1; one-cycle wakeup-to-issue latency.
- Issue:
  - The selected entry's type, val1, val2 and rob_id are registered onto alu_*; alu_valid=1 for exactly that cycle; the entry is cleared.
  - If no entry is ready, alu_valid=0 and the other alu_* outputs hold their last values.
- Minimum latency: dispatch with no deps at edge t makes the entry busy/ready after edge t; alu_valid=1 after edge t+1.
- Same-index events: the free-slot search excludes only registered busy entries, so a slot freed by issue is not reused in the same cycle.
- M-ext types (type[5]=1) are stored and issued unchanged; no filtering here.

Test Plan:
- Reset, then dispatch type=0, r1=5, r2=7, rob=3, no deps -> two edges later alu_valid=1, r1=5, r2=7, rob_id=3; alu_valid=0 the following cycle.
- Dispatch r1 dep on rob 2, r2=1; after 3 idle cycles pulse alu_res_ready with rob 2, value 0x10 -> alu_valid=1 one cycle after the broadcast edge, r1=0x10, r2=1.
- Dispatch an op with dep on rob 5 while lsb_res_ready carries rob 5, value 9 in the same cycle -> issued with r1=9 and no further wait.
- Fill 8 entries, all with deps on rob 15 -> full=1; a 9th dispatch is ignored. Broadcast rob 15 -> entries issue in index order 0..7 on consecutive cycles, and full drops after the first issue.
- Hold rdy_in=0 for 4 cycles with ready entries -> alu_valid and all state frozen; issue resumes unchanged when rdy_in=1.
- Flush with 5 busy entries and an issue pending -> next cycle full=0, alu_valid=0, and no issues ever appear for the flushed rob ids. Asserting rst_in mid-cycle clears alu_valid immediately without a clock edge.
